// File: rtl/cache_dre_fill.sv
// Line-fill controller: walks a cache line in mask-entry pairs, fetches every word that is not
// fully readable, merges only its non-readable bytes into the data RAM and marks the entry readable.
module cache_dre_fill #(
    parameter int ADDR_WIDTH      = 8,
    parameter int LINE_WORDS_LOG2 = 3,
    parameter int TAG_WIDTH       = 22
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] startLine,
    input  logic [1:0]                      startChannel,
    input  logic [TAG_WIDTH-1:0]            startTag,
    output logic                            busy,
    output logic                            done,
    output logic                            sel,
    output logic [ADDR_WIDTH-1:0]           ri_readAddress,
    output logic [1:0]                      ri_readChannel,
    input  logic [7:0]                      ri_readData,
    output logic [ADDR_WIDTH-1:0]           ri_writeAddress,
    output logic [1:0]                      ri_writeChannel,
    output logic                            ri_writeEnable,
    output logic [7:0]                      ri_writeData,
    output logic [TAG_WIDTH+ADDR_WIDTH-1:0] mem_address,
    output logic                            mem_read,
    input  logic                            mem_waitRequest,
    input  logic                            mem_readDataValid,
    input  logic [31:0]                     mem_readData,
    output logic [ADDR_WIDTH-1:0]           ram_writeAddress,
    output logic [1:0]                      ram_writeChannel,
    output logic [31:0]                     ram_writeData,
    output logic [3:0]                      ram_writeByteEnable,
    output logic                            ram_writeEnable
);
    localparam int LINE_W = ADDR_WIDTH - LINE_WORDS_LOG2;
    localparam int PAIR_W = (LINE_WORDS_LOG2 > 1) ? (LINE_WORDS_LOG2 - 1) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'((1 << (LINE_WORDS_LOG2 - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_CHECK    = 3'd3,
        S_MEM_REQ  = 3'd4,
        S_MEM_WAIT = 3'd5,
        S_WR_DRE   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t                state_r;
    state_t                state_n;
    logic [LINE_W-1:0]     line_r;
    logic [1:0]            chan_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    logic [PAIR_W-1:0]     pair_cnt_r;
    logic                  word_sel_r;
    logic [7:0]            mask_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  sel_r;
    logic                  mem_read_r;
    logic                  ri_we_r;

    logic                  latch_s;
    logic                  load_mask_s;
    logic                  set_ws_s;
    logic                  next_pair_s;
    logic                  ram_we_s;
    logic [3:0]            nib_s;
    logic [ADDR_WIDTH-1:0] pair_addr_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;

    // Mask-store address is held for the whole pair because its read port is registered.
    assign pair_addr_s = {line_r, {LINE_WORDS_LOG2{1'b0}}} | (ADDR_WIDTH'(pair_cnt_r) << 1);
    assign word_addr_s = pair_addr_s | ADDR_WIDTH'(word_sel_r);
    assign nib_s       = word_sel_r ? mask_r[7:4] : mask_r[3:0];

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_n     = state_r;
        latch_s     = 1'b0;
        load_mask_s = 1'b0;
        set_ws_s    = 1'b0;
        next_pair_s = 1'b0;
        ram_we_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    latch_s = 1'b1;
                    state_n = S_RD_REQ;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RD_REQ: state_n = S_RD_WAIT;
            S_RD_WAIT: begin
                load_mask_s = 1'b1;
                state_n     = S_CHECK;
            end
            S_CHECK: begin
                if (nib_s != 4'hF) begin
                    state_n = S_MEM_REQ;
                end else if (!word_sel_r) begin
                    set_ws_s = 1'b1;
                end else if (mask_r != 8'hFF) begin
                    state_n = S_WR_DRE;
                end else if (pair_cnt_r == LAST_PAIR) begin
                    // Entry already fully readable: skip the mask write.
                    state_n = S_DONE;
                end else begin
                    next_pair_s = 1'b1;
                    state_n     = S_RD_REQ;
                end
            end
            S_MEM_REQ: begin
                if (!mem_waitRequest) begin
                    state_n = S_MEM_WAIT;
                end else begin
                    state_n = S_MEM_REQ;
                end
            end
            S_MEM_WAIT: begin
                if (mem_readDataValid) begin
                    ram_we_s = 1'b1;
                    if (!word_sel_r) begin
                        set_ws_s = 1'b1;
                        state_n  = S_CHECK;
                    end else begin
                        state_n = S_WR_DRE;
                    end
                end else begin
                    state_n = S_MEM_WAIT;
                end
            end
            S_WR_DRE: begin
                if (pair_cnt_r == LAST_PAIR) begin
                    state_n = S_DONE;
                end else begin
                    next_pair_s = 1'b1;
                    state_n     = S_RD_REQ;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, latched request, pair/word walk and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            line_r     <= {LINE_W{1'b0}};
            chan_r     <= 2'b00;
            tag_r      <= {TAG_WIDTH{1'b0}};
            pair_cnt_r <= {PAIR_W{1'b0}};
            word_sel_r <= 1'b0;
            mask_r     <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sel_r      <= 1'b0;
            mem_read_r <= 1'b0;
            ri_we_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            busy_r     <= (state_n != S_IDLE);
            sel_r      <= (state_n != S_IDLE);
            done_r     <= (state_n == S_DONE);
            mem_read_r <= (state_n == S_MEM_REQ);
            ri_we_r    <= (state_n == S_WR_DRE);
            if (latch_s) begin
                line_r     <= startLine;
                chan_r     <= startChannel;
                tag_r      <= startTag;
                pair_cnt_r <= {PAIR_W{1'b0}};
            end else if (next_pair_s) begin
                pair_cnt_r <= pair_cnt_r + PAIR_W'(1);
            end
            if (load_mask_s) begin
                mask_r     <= ri_readData;
                word_sel_r <= 1'b0;
            end else if (set_ws_s) begin
                word_sel_r <= 1'b1;
            end
        end
    end

    assign busy                = busy_r;
    assign done                = done_r;
    assign sel                 = sel_r;
    assign ri_readAddress      = pair_addr_s;
    assign ri_readChannel      = chan_r;
    assign ri_writeAddress     = pair_addr_s;
    assign ri_writeChannel     = chan_r;
    assign ri_writeEnable      = ri_we_r;
    assign ri_writeData        = ri_we_r ? 8'hFF : 8'h00;
    assign mem_address         = {tag_r, word_addr_s};
    assign mem_read            = mem_read_r;
    // The RAM write lands in the same cycle the memory word is valid.
    assign ram_writeEnable     = ram_we_s;
    assign ram_writeAddress    = word_addr_s;
    assign ram_writeChannel    = chan_r;
    assign ram_writeData       = ram_we_s ? mem_readData : 32'h0000_0000;
    assign ram_writeByteEnable = ram_we_s ? ~nib_s : 4'h0;

endmodule

// File: tb/tb_cache_dre_fill.sv
// Bench for cache_dre_fill: mask store, data RAM and memory responder models with scoreboards
// for RAM writes, memory requests, mask writes and mask read addresses.
module tb_cache_dre_fill;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  startLine = 5'd0;
    logic [1:0]  startChannel = 2'd0;
    logic [21:0] startTag = 22'd0;
    logic        busy, done, sel;
    logic [7:0]  ri_readAddress, ri_writeAddress;
    logic [1:0]  ri_readChannel, ri_writeChannel;
    logic [7:0]  ri_readData = 8'h00;
    logic        ri_writeEnable;
    logic [7:0]  ri_writeData;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_waitRequest = 1'b0;
    logic        mem_readDataValid = 1'b0;
    logic [31:0] mem_readData = 32'h0;
    logic [7:0]  ram_writeAddress;
    logic [1:0]  ram_writeChannel;
    logic [31:0] ram_writeData;
    logic [3:0]  ram_writeByteEnable;
    logic        ram_writeEnable;

    cache_dre_fill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .startLine(startLine),
        .startChannel(startChannel), .startTag(startTag), .busy(busy), .done(done), .sel(sel),
        .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel), .ri_readData(ri_readData),
        .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
        .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
        .mem_address(mem_address), .mem_read(mem_read), .mem_waitRequest(mem_waitRequest),
        .mem_readDataValid(mem_readDataValid), .mem_readData(mem_readData),
        .ram_writeAddress(ram_writeAddress), .ram_writeChannel(ram_writeChannel),
        .ram_writeData(ram_writeData), .ram_writeByteEnable(ram_writeByteEnable),
        .ram_writeEnable(ram_writeEnable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with nothing expected", nm);
    endtask

    // Mask store (registered read) and byte-enabled data RAM models.
    logic [7:0]  mask_mem [4][256];
    logic [7:0]  pre_mask [4][256];
    logic [31:0] ram_mem  [4][256];
    logic [31:0] pre_ram  [4][256];
    logic        do_load = 1'b0;

    always @(posedge clk) begin
        ri_readData <= mask_mem[ri_readChannel][ri_readAddress];
        if (do_load) begin
            for (int c = 0; c < 4; c++)
                for (int a = 0; a < 256; a++) begin
                    mask_mem[c][a] <= pre_mask[c][a];
                    ram_mem[c][a]  <= pre_ram[c][a];
                end
        end else begin
            if (ri_writeEnable) mask_mem[ri_writeChannel][ri_writeAddress] <= ri_writeData;
            if (ram_writeEnable)
                for (int b = 0; b < 4; b++)
                    if (ram_writeByteEnable[b])
                        ram_mem[ram_writeChannel][ram_writeAddress][8*b +: 8] <= ram_writeData[8*b +: 8];
        end
    end

    // Memory responder: cfg_stall cycles of waitRequest, then valid cfg_lat cycles after accept.
    int          cfg_stall = 0;
    int          cfg_lat = 1;
    int          stall_left = 0;
    int          resp_cnt = 0;
    bit          req_seen = 1'b0;
    logic [29:0] resp_addr = 30'd0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_readDataValid = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
                req_seen = 1'b0;
                mem_waitRequest = 1'b0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        mem_readDataValid = 1'b1;
                        mem_readData = 32'(resp_addr);
                    end
                end
                if (mem_read) begin
                    if (!req_seen) begin
                        req_seen = 1'b1;
                        stall_left = cfg_stall;
                    end
                    if (stall_left > 0) begin
                        mem_waitRequest = 1'b1;
                        stall_left--;
                    end else begin
                        mem_waitRequest = 1'b0;
                        resp_cnt = cfg_lat;
                        resp_addr = mem_address;
                    end
                end else begin
                    mem_waitRequest = 1'b0;
                    req_seen = 1'b0;
                end
            end
        end
    end

    // Scoreboards, filled when a fill is launched and drained as the DUT acts.
    logic [45:0] exp_ram [$];
    logic [29:0] exp_mem [$];
    logic [9:0]  exp_ri  [$];
    logic [9:0]  exp_ra  [$];
    int          n_mem_acc = 0;
    int          n_ri_wr = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b1;
    bit          prev_sel = 1'b0;
    logic [7:0]  last_ra = 8'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mon_en && rst_n) begin
                if (ram_writeEnable) begin
                    if (exp_ram.size() == 0) unexpected("ram_write");
                    else chk("ram_write", {ram_writeChannel, ram_writeAddress, ram_writeByteEnable,
                                           ram_writeData}, exp_ram.pop_front());
                end
                if (mem_read) begin
                    if (exp_mem.size() == 0) unexpected("mem_read");
                    else begin
                        chk("mem_address", mem_address, exp_mem[0]);
                        if (!mem_waitRequest) begin
                            void'(exp_mem.pop_front());
                            n_mem_acc++;
                        end
                    end
                end
                if (ri_writeEnable) begin
                    n_ri_wr++;
                    if (exp_ri.size() == 0) unexpected("ri_write");
                    else chk("ri_write", {ri_writeChannel, ri_writeAddress, ri_writeData},
                             {exp_ri.pop_front(), 8'hFF});
                end
                if (sel && (!prev_sel || ri_readAddress != last_ra)) begin
                    if (exp_ra.size() == 0) unexpected("ri_read_addr");
                    else chk("ri_read_addr", {ri_readChannel, ri_readAddress}, exp_ra.pop_front());
                end
            end
            prev_sel = sel;
            last_ra = ri_readAddress;
        end
    end

    typedef struct {
        logic [4:0]  line;
        logic [1:0]  ch;
        logic [21:0] tag;
        logic [31:0] masks;
        int          stall;
        int          lat;
        bit          busy_start;
        int          exp_done;
        int          exp_reads;
        int          exp_riw;
    } tvec_t;

    tvec_t vecs [6];

    function automatic logic [109:0] all_outs();
        return {busy, done, sel, ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
                ri_writeEnable, ri_writeData, mem_address, mem_read, ram_writeAddress,
                ram_writeChannel, ram_writeData, ram_writeByteEnable, ram_writeEnable};
    endfunction

    task automatic run_fill(input tvec_t v);
        logic [7:0]  m;
        logic [7:0]  ea;
        logic [7:0]  wa;
        logic [3:0]  nib;
        logic [31:0] md;
        logic [31:0] want;
        int          cyc;
        int          done_base;
        bit          got;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) begin
                pre_mask[c][a] = 8'h00;
                pre_ram[c][a]  = 32'hC0DE_0000 | (32'(c) << 8) | 32'(a);
            end
        for (int p = 0; p < 4; p++) pre_mask[v.ch][{v.line, 2'(p), 1'b0}] = v.masks[8*p +: 8];
        @(negedge clk);
        do_load = 1'b1;
        @(posedge clk);
        #1;
        do_load = 1'b0;
        cfg_stall = v.stall;
        cfg_lat = v.lat;
        n_mem_acc = 0;
        n_ri_wr = 0;
        for (int p = 0; p < 4; p++) begin
            m  = v.masks[8*p +: 8];
            ea = {v.line, 2'(p), 1'b0};
            exp_ra.push_back({v.ch, ea});
            for (int w = 0; w < 2; w++) begin
                nib = (w == 1) ? m[7:4] : m[3:0];
                wa  = ea | 8'(w);
                if (nib != 4'hF) begin
                    exp_mem.push_back({v.tag, wa});
                    exp_ram.push_back({v.ch, wa, ~nib, 32'({v.tag, wa})});
                end
            end
            if (m != 8'hFF) exp_ri.push_back({v.ch, ea});
        end
        done_base = done_cnt;
        @(negedge clk);
        startLine = v.line;
        startChannel = v.ch;
        startTag = v.tag;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (v.busy_start && cyc == 6) begin
                startLine = v.line ^ 5'd31;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", got, 1'b1);
        chk("done_cycle", cyc, v.exp_done);
        @(negedge clk);
        chk("idle_after_done", {sel, busy, done}, 3'b000);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - done_base, 1);
        chk("ram_left", exp_ram.size(), 0);
        chk("mem_left", exp_mem.size(), 0);
        chk("ri_left", exp_ri.size(), 0);
        chk("ra_left", exp_ra.size(), 0);
        chk("mem_reads", n_mem_acc, v.exp_reads);
        chk("ri_writes", n_ri_wr, v.exp_riw);
        for (int p = 0; p < 4; p++) begin
            ea = {v.line, 2'(p), 1'b0};
            chk("mask_final", mask_mem[v.ch][ea], 8'hFF);
            if (v.busy_start) chk("other_line_mask", mask_mem[v.ch][{v.line ^ 5'd31, 2'(p), 1'b0}], 8'h00);
            for (int w = 0; w < 2; w++) begin
                m   = v.masks[8*p +: 8];
                nib = (w == 1) ? m[7:4] : m[3:0];
                wa  = ea | 8'(w);
                md  = 32'({v.tag, wa});
                for (int b = 0; b < 4; b++)
                    want[8*b +: 8] = nib[b] ? pre_ram[v.ch][wa][8*b +: 8] : md[8*b +: 8];
                chk("ram_final", ram_mem[v.ch][wa], want);
            end
        end
    endtask

    initial begin
        int k;
        int base;
        vecs[0] = '{5'd2,  2'd1, 22'h12345, 32'hFFFF_FFFF, 0, 1, 1'b0, 17, 0, 0};
        vecs[1] = '{5'd5,  2'd0, 22'h3ABCD, 32'h0000_0000, 0, 1, 1'b0, 37, 8, 4};
        vecs[2] = '{5'd7,  2'd2, 22'h00F0F, 32'hFFFF_FF3C, 0, 1, 1'b0, 22, 2, 1};
        vecs[3] = '{5'd1,  2'd3, 22'h2AAAA, 32'hFFFF_FFF0, 5, 3, 1'b0, 27, 1, 1};
        vecs[4] = '{5'd31, 2'd0, 22'h3FFFF, 32'hE7FF_A50F, 1, 2, 1'b0, 40, 5, 3};
        vecs[5] = '{5'd9,  2'd2, 22'h15555, 32'h0000_0000, 0, 1, 1'b1, 37, 8, 4};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 110'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_fill(vecs[i]);

        // Reset while a memory read is outstanding.
        mon_en = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) pre_mask[c][a] = 8'h00;
        @(negedge clk);
        do_load = 1'b1;
        @(posedge clk);
        #1;
        do_load = 1'b0;
        cfg_stall = 0;
        cfg_lat = 60;
        base = done_cnt;
        @(negedge clk);
        startLine = 5'd4;
        startChannel = 2'd1;
        startTag = 22'h0BEEF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!mem_read && k < 100) begin @(negedge clk); k++; end
        chk("rst_reach_mem_req", mem_read, 1'b1);
        k = 0;
        while (mem_read && k < 100) begin @(negedge clk); k++; end
        chk("rst_reach_mem_wait", {mem_read, busy}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", all_outs(), 110'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - base, 0);
        chk("rst_mid_held", all_outs(), 110'd0);
        rst_n = 1'b1;
        exp_ram.delete();
        exp_mem.delete();
        exp_ri.delete();
        exp_ra.delete();
        @(negedge clk);
        mon_en = 1'b1;
        run_fill(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_dre_fill.md
Name: cache_dre_fill

Overview:
- Line-fill controller that consumes the per-byte readable-mask store through its ri port.
- On a miss it takes ownership of the mask store (sel=1) and walks every word of the target line in mask entries of two words each.
- For each word not fully readable, it fetches the word from memory and writes only the non-readable bytes into the data RAM, so CPU-written bytes are preserved.
- It then marks the whole entry readable (8'hFF) and returns control with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 8: word-address width into the mask/data RAM space; one mask entry per even/odd word pair.
- LINE_WORDS_LOG2, 3: log2 of words per line; must be at least 1; pairs per line = 2^(LINE_WORDS_LOG2-1).
- TAG_WIDTH, 22: tag bits prepended to form the memory word address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  fill request; sampled only in IDLE
- startLine  in  ADDR_WIDTH-LINE_WORDS_LOG2  line index
- startChannel  in  2  way/channel to fill
- startTag  in  TAG_WIDTH  tag of the missing line
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- sel  out  1  mask-store ownership; drives the store's sel input
- ri_readAddress  out  ADDR_WIDTH  even word address of the current pair
- ri_readChannel  out  2  latched channel
- ri_readData  in  8  mask entry; [3:0] = even word, [7:4] = odd word
- ri_writeAddress  out  ADDR_WIDTH  equal to ri_readAddress
- ri_writeChannel  out  2  latched channel
- ri_writeEnable  out  1  mask write strobe
- ri_writeData  out  8  constant 8'hFF
- mem_address  out  TAG_WIDTH+ADDR_WIDTH  {tag, line, pair, wordSel}
- mem_read  out  1  memory read request
- mem_waitRequest  in  1  memory stall
- mem_readDataValid  in  1  read data valid
- mem_readData  in  32  memory word
- ram_writeAddress  out  ADDR_WIDTH  data RAM word address
- ram_writeChannel  out  2  data RAM channel
- ram_writeData  out  32  equal to mem_readData
- ram_writeByteEnable  out  4  inverse of the word's readable nibble
- ram_writeEnable  out  1  data RAM write strobe

Behaviour:
- Reset: async to IDLE; pairCnt=0, wordSel=0, mask=0.
  - Outputs busy, done, sel, ri_writeEnable, mem_read and ram_writeEnable are 0.
  - All address/data outputs are 0.
  - Reset mid-fill abandons the fill with no done pulse; partially written bytes remain.
- States: IDLE, RD_REQ, RD_WAIT, CHECK, MEM_REQ, MEM_WAIT, WR_DRE, DONE.
- IDLE: on start, latch line/channel/tag, set pairCnt=0, go to RD_REQ. start while busy is ignored.
- sel=1 in every state from RD_REQ to DONE inclusive.
- ri_readAddress is held at {line, pairCnt, 1'b0} for the whole pair, because the mask RAM has 1-cycle registered read.
- RD_REQ: 1 cycle, then RD_WAIT.
- RD_WAIT: mask <= ri_readData; wordSel=0; go to CHECK.
- CHECK: nib = wordSel ? mask[7:4] : mask[3:0].
  - nib != 4'hF: go to MEM_REQ.
  - nib == 4'hF and wordSel=0: set wordSel=1, stay in CHECK.
  - nib == 4'hF and wordSel=1: go to WR_DRE, or skip WR_DRE if mask == 8'hFF (advance directly as WR_DRE would).
- MEM_REQ: mem_read=1 with mem_address stable; leave to MEM_WAIT on the first cycle with mem_waitRequest=0.
- MEM_WAIT: mem_read=0; wait for mem_readDataValid.
  - In that same cycle, combinationally assert ram_writeEnable=1 for 1 cycle, with ram_writeAddress = {line, pairCnt, wordSel}, channel latched, and ram_writeByteEnable = ~nib.
  - Then if wordSel=0: wordSel=1, go to CHECK. Otherwise go to WR_DRE.
  - mem_readDataValid outside MEM_WAIT is ignored.
- WR_DRE: ri_writeEnable=1 for 1 cycle with data 8'hFF. Then if pairCnt is the last pair go to DONE, else pairCnt+1 and go to RD_REQ.
- DONE: done=1, sel=1 for 1 cycle, then IDLE. start may be accepted in the following IDLE cycle.
- One outstanding memory read at a time; no burst.
- The external arbiter must stall rw-side mask writes while sel=1.
- Latency, fully readable line, default parameters: done is high in cycle 17 after the start sample edge (4 cycles per pair x 4 pairs + DONE).

Test Plan:
- Fully readable line: mask store preloaded 8'hFF for all 4 pairs, start line 2, channel 1.
  - Required: no mem_read and no ri_writeEnable; reads at addresses 16, 18, 20, 22; done in cycle 17; sel falls the cycle after done.
- Empty line: all masks 8'h00, zero-wait memory returning data = address.
  - Required: 8 reads; ram_writeByteEnable=4'hF each time; 4 ri writes of 8'hFF; final masks all 8'hFF.
- Partial mask: pair 0 mask 8'h3C.
  - Required: word 0 written with byte enable 4'h3; word 1 written with byte enable 4'hC; untouched bytes keep CPU data; mask becomes 8'hFF.
- Memory stall: mem_waitRequest held 5 cycles, then readDataValid 3 cycles later.
  - Required: mem_read and mem_address stable throughout the stall; exactly one ram write.
- Start while busy: second start pulse mid-fill with a different line.
  - Required: ignored; only the first line is filled; a single done pulse.
- Reset mid-fill: rst_n low during MEM_WAIT.
  - Required: all outputs 0 immediately; no done; a new start after reset completes a normal fill.
